// File: rtl/stepper_plunge_seq.sv
// Plunge sequencer for a bank of 4-phase steppers: each channel with a nonzero round
// count is driven DEPTH steps forward and DEPTH steps back per round, with idle gaps between channels.
module stepper_plunge_seq #(
    parameter int NCH      = 3,
    parameter int CNT_W    = 10,
    parameter int STEP_DIV = 2**19,
    parameter int DEPTH    = 5,
    parameter int MOVE     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NCH*CNT_W-1:0] rounds,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           cur_ch,
    output logic [4*NCH-1:0]     coils
);
    // state  | meaning
    // IDLE   | waiting for start
    // SELECT | pick lowest channel >= ch_q with rounds left (one cycle)
    // FWD    | stepping forward, DEPTH ticks
    // REV    | stepping back, DEPTH ticks, then count the round
    // GAP    | coils off for MOVE ticks before the next channel
    // FINISH | done pulse, then back to IDLE

    localparam int PRE_W = $clog2(STEP_DIV);
    localparam int STP_W = $clog2(DEPTH + 1);
    localparam int GAP_W = (MOVE > 1) ? $clog2(MOVE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [STP_W-1:0] STP_LAST = STP_W'(DEPTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((MOVE > 0) ? MOVE - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_FWD, S_REV, S_GAP, S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [NCH*CNT_W-1:0] rounds_q, rounds_d;
    logic [2:0]           ch_q, ch_d;
    logic [CNT_W-1:0]     rnd_q, rnd_d;
    logic [STP_W-1:0]     stp_q, stp_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [1:0]           ph_q, ph_d;
    logic [4*NCH-1:0]     coils_q, coils_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 tick;
    logic [CNT_W-1:0]     cur_rounds;
    logic [CNT_W-1:0]     rnd_inc;
    logic                 sel_found;
    logic [2:0]           sel_idx;
    logic                 later_nz;

    function automatic logic [3:0] phase_pat(input logic [1:0] p);
        case (p)
            2'd0:    phase_pat = 4'b0001;
            2'd1:    phase_pat = 4'b1000;
            2'd2:    phase_pat = 4'b0100;
            default: phase_pat = 4'b0010;
        endcase
    endfunction

    function automatic logic [4*NCH-1:0] drive(input logic [2:0] ch, input logic [1:0] p);
        drive = '0;
        for (int i = 0; i < NCH; i++) begin
            if (3'(i) == ch) drive[4*i +: 4] = phase_pat(p);
        end
    endfunction

    assign tick    = (state_q != S_IDLE) && (pre_q == PRE_LAST);
    assign rnd_inc = rnd_q + CNT_W'(1);

    always_comb begin
        logic nz_i;
        nz_i       = 1'b0;
        cur_rounds = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        later_nz   = 1'b0;
        // Descending scan so the lowest qualifying index wins.
        for (int i = NCH - 1; i >= 0; i--) begin
            nz_i = |rounds_q[i*CNT_W +: CNT_W];
            if (3'(i) == ch_q) cur_rounds = rounds_q[i*CNT_W +: CNT_W];
            if (nz_i && (3'(i) >= ch_q)) begin
                sel_found = 1'b1;
                sel_idx   = 3'(i);
            end
            if (nz_i && (3'(i) > ch_q)) later_nz = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        rounds_d = rounds_q;
        ch_d     = ch_q;
        rnd_d    = rnd_q;
        stp_d    = stp_q;
        gap_d    = gap_q;
        ph_d     = ph_q;
        coils_d  = coils_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (state_q == S_IDLE || pre_q == PRE_LAST) pre_d = '0;
        else                                        pre_d = pre_q + PRE_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d  = S_SELECT;
                    rounds_d = rounds;
                    busy_d   = 1'b1;
                    pre_d    = '0;
                    ch_d     = '0;
                    rnd_d    = '0;
                    stp_d    = '0;
                    gap_d    = '0;
                    ph_d     = 2'd0;
                    coils_d  = '0;
                end
            end
            S_SELECT: begin
                if (sel_found) begin
                    state_d = S_FWD;
                    ch_d    = sel_idx;
                    rnd_d   = '0;
                    stp_d   = '0;
                    ph_d    = 2'd0;
                    coils_d = drive(sel_idx, 2'd0);
                end else begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    coils_d = '0;
                end
            end
            S_FWD: begin
                if (tick) begin
                    ph_d    = ph_q + 2'd1;
                    coils_d = drive(ch_q, ph_q + 2'd1);
                    if (stp_q == STP_LAST) begin
                        stp_d   = '0;
                        state_d = S_REV;
                    end else begin
                        stp_d = stp_q + STP_W'(1);
                    end
                end
            end
            S_REV: begin
                if (tick) begin
                    ph_d    = ph_q - 2'd1;
                    coils_d = drive(ch_q, ph_q - 2'd1);
                    if (stp_q != STP_LAST) begin
                        stp_d = stp_q + STP_W'(1);
                    end else begin
                        stp_d = '0;
                        rnd_d = rnd_inc;
                        if (rnd_inc < cur_rounds) begin
                            state_d = S_FWD;
                        end else if (later_nz) begin
                            coils_d = '0;
                            gap_d   = '0;
                            if (MOVE == 0) begin
                                state_d = S_SELECT;
                                ch_d    = ch_q + 3'd1;
                            end else begin
                                state_d = S_GAP;
                            end
                        end else begin
                            state_d = S_FINISH;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            coils_d = '0;
                        end
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_SELECT;
                        ch_d    = ch_q + 3'd1;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                ch_d    = '0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                coils_d = '0;
            end
        endcase

        // Abort wins over any in-flight transition, including a completion on the same edge.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            coils_d = '0;
            ch_d    = '0;
            pre_d   = '0;
            rnd_d   = '0;
            stp_d   = '0;
            gap_d   = '0;
            ph_d    = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            rounds_q <= '0;
            ch_q     <= '0;
            rnd_q    <= '0;
            stp_q    <= '0;
            gap_q    <= '0;
            ph_q     <= 2'd0;
            coils_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            rounds_q <= rounds_d;
            ch_q     <= ch_d;
            rnd_q    <= rnd_d;
            stp_q    <= stp_d;
            gap_q    <= gap_d;
            ph_q     <= ph_d;
            coils_q  <= coils_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign coils  = coils_q;
    assign cur_ch = (state_q == S_SELECT || state_q == S_FWD ||
                     state_q == S_REV    || state_q == S_GAP) ? ch_q : 3'd0;

endmodule

// File: tb/tb_stepper_plunge_seq.sv
// Bench for stepper_plunge_seq: interval-based timeline model checked every cycle,
// plus directed literal checks for timing, phase order, abort and reset.
module tb_stepper_plunge_seq;
    localparam int NCH = 3, CNT_W = 10, STEP_DIV = 4, DEPTH = 5, MOVE = 2, MAXE = 512;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [NCH*CNT_W-1:0] rounds_in = '0;
    logic                 busy, done;
    logic [2:0]           cur_ch;
    logic [4*NCH-1:0]     coils;

    stepper_plunge_seq #(.NCH(NCH), .CNT_W(CNT_W), .STEP_DIV(STEP_DIV),
                         .DEPTH(DEPTH), .MOVE(MOVE)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rounds(rounds_in),
        .busy(busy), .done(done), .cur_ch(cur_ch), .coils(coils));

    initial forever #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, acc = 0, done_edge = 0;
    bit chk_on = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs indexed by edges since acceptance (value seen after that edge).
    bit               eb [MAXE];
    bit               ed [MAXE];
    bit               ek [MAXE];
    logic [4*NCH-1:0] ec [MAXE];
    logic [2:0]       ech[MAXE];

    function automatic logic [3:0] pat(input int p);
        case (p)
            0:       return 4'b0001;
            1:       return 4'b1000;
            2:       return 4'b0100;
            default: return 4'b0010;
        endcase
    endfunction

    task automatic apply_abort(input int a);
        for (int k = a; k < MAXE; k++) begin
            eb[k] = 0; ed[k] = 0; ek[k] = 1; ec[k] = '0; ech[k] = '0;
        end
    endtask

    task automatic build_expect(input int r0, input int r1, input int r2);
        int r[3];
        int chs[$];
        int b, c, rlen, e0, e1, m, q, h;
        r = '{r0, r1, r2};
        apply_abort(0);
        for (int i = 0; i < NCH; i++) if (r[i] != 0) chs.push_back(i);
        eb[0] = 1; ek[0] = 0;
        if (chs.size() == 0) begin
            ed[1] = 1; ek[1] = 0; done_edge = 1;
            return;
        end
        b = 0;
        for (int j = 0; j < chs.size(); j++) begin
            c    = chs[j];
            rlen = 2 * DEPTH * r[c];
            e0   = STEP_DIV * b + 1;
            e1   = STEP_DIV * (b + rlen);
            for (int k = e0; k < e1; k++) begin
                m = k / STEP_DIV - b;
                q = m % (2 * DEPTH);
                h = (q <= DEPTH) ? q : 2 * DEPTH - q;
                eb[k] = 1; ek[k] = 1; ech[k] = 3'(c);
                ec[k] = 12'(pat(h % 4)) << (4 * c);
            end
            if (j < chs.size() - 1) begin
                for (int k = e1; k < STEP_DIV * (b + rlen + MOVE); k++) begin
                    eb[k] = 1; ek[k] = 1; ech[k] = 3'(c); ec[k] = '0;
                end
                eb[STEP_DIV * (b + rlen + MOVE)] = 1;
                ek[STEP_DIV * (b + rlen + MOVE)] = 0;
                b = b + rlen + MOVE;
            end else begin
                ed[e1] = 1; ek[e1] = 0; done_edge = e1;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    int cidx;
    always @(negedge clk) begin
        if (chk_on) begin
            cidx = cyc - acc;
            if (cidx >= 0 && cidx < MAXE) begin
                n_cmp++;
                if (busy !== eb[cidx] || done !== ed[cidx] || coils !== ec[cidx] ||
                    (ek[cidx] && cur_ch !== ech[cidx])) begin
                    n_bad++;
                    $display("FAIL model idx=%0d busy=%0b/%0b done=%0b/%0b coils=%h/%h cur_ch=%0d/%0d",
                             cidx, busy, eb[cidx], done, ed[cidx], coils, ec[cidx],
                             cur_ch, ech[cidx]);
                end
            end
        end
    end

    task automatic lit(input int mode, input int n);
        int lt[11];
        lt = '{1, 8, 4, 2, 1, 8, 1, 2, 4, 8, 0};
        case (mode)
            1: begin
                if (n <= 128) check("ch1_quiet", int'(coils[7:4]), 0);
                if (n == 127) check("done_not_early", int'(done), 0);
                if (n == 128) begin
                    check("done_at_128", int'(done), 1);
                    check("busy_clr_128", int'(busy), 0);
                end
            end
            2: begin
                if (n == 1) check("entry_0001", int'(coils[3:0]), lt[0]);
                if (n % 4 == 0 && n / 4 >= 1 && n / 4 <= 10)
                    check($sformatf("phase_tick%0d", n / 4), int'(coils[3:0]), lt[n / 4]);
                if (n == 40) check("done_tick10", int'(done), 1);
            end
            3: begin
                if (n == 1) begin
                    check("zero_done", int'(done), 1);
                    check("zero_busy1", int'(busy), 0);
                    check("zero_coils", int'(coils), 0);
                end
            end
            4: begin
                if (n == 32) begin
                    check("abort_busy", int'(busy), 0);
                    check("abort_coils", int'(coils), 0);
                    check("abort_done", int'(done), 0);
                end
            end
            default: ;
        endcase
    endtask

    task automatic run_seq(input int r0, input int r1, input int r2,
                           input int ab, input int rs, input int mode, input int rst_at);
        int last;
        build_expect(r0, r1, r2);
        if (ab > 0) apply_abort(ab);
        last = ((ab > 0) ? ab : done_edge) + 3;
        @(posedge clk); #2;
        rounds_in = {10'(r2), 10'(r1), 10'(r0)};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; acc = cyc; chk_on = 1'b1;
        rounds_in = 30'($urandom);
        if (mode == 3) check("zero_busy0", int'(busy), 1);
        for (int n = 1; n <= last; n++) begin
            #1;
            abort = (n == ab);
            start = (n == rs);
            if (n == rs) rounds_in = 30'($urandom);
            @(posedge clk); #1;
            lit(mode, n);
            if (n == rst_at) begin
                chk_on = 1'b0;
                #2 rst = 1'b0;
                #1;
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_coils", int'(coils), 0);
                check("rst_cur_ch", int'(cur_ch), 0);
                break;
            end
        end
        abort = 1'b0; start = 1'b0; chk_on = 1'b0;
    endtask

    task automatic idle_window(input int ncyc);
        apply_abort(0);
        #2 acc = cyc; chk_on = 1'b1;
        repeat (ncyc) @(posedge clk);
        #1 chk_on = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r1, r2, ab, rs, lim;
        #1 rst = 1'b0;
        #1;
        check("por_busy", int'(busy), 0);
        check("por_done", int'(done), 0);
        check("por_coils", int'(coils), 0);
        check("por_cur_ch", int'(cur_ch), 0);
        @(posedge clk); #2 rst = 1'b1;

        run_seq(1, 0, 0, 0, 0, 2, 0);
        run_seq(2, 0, 1, 0, 50, 1, 0);
        run_seq(0, 0, 0, 0, 0, 3, 0);
        run_seq(2, 0, 1, 32, 0, 4, 0);

        // start together with abort in IDLE must be rejected
        apply_abort(0);
        @(posedge clk); #2;
        acc = cyc; chk_on = 1'b1;
        rounds_in = {10'd1, 10'd1, 10'd1};
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk_on = 1'b0;
        check("abort_start_rejected", int'(busy), 0);

        for (int it = 0; it < 12; it++) begin
            r0 = $urandom_range(0, 3);
            r1 = $urandom_range(0, 3);
            r2 = $urandom_range(0, 3);
            build_expect(r0, r1, r2);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, done_edge) : 0;
            lim = (ab > 0) ? ab - 1 : done_edge;
            rs  = ($urandom_range(0, 2) == 0 && lim >= 1) ? $urandom_range(1, lim) : 0;
            run_seq(r0, r1, r2, ab, rs, 0, 0);
        end

        run_seq(1, 0, 1, 0, 0, 0, 58);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        idle_window(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
